// File: rtl/clock_time_counter.sv
// Time-of-day counter in packed BCD with RUN/SET modes, fed by the 1 Hz divider.
// Optional 12 h display remap when CLOCK_12H_EN is defined (internal hour stays 24 h).
module clock_time_counter #(
  parameter logic [7:0] INIT_HOUR = 8'h00,
  parameter logic [7:0] INIT_MIN  = 8'h00
) (
  input  logic       clk_100mhz,
  input  logic       rst_100mhz,
  input  logic       in_1hz,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       tick_sec,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       pm
);

  typedef enum logic {RUN, SET} state_t;

  state_t     state, state_nxt;
  logic       in_d;
  logic       tick;
  logic [7:0] sec_q, min_q, hour_q;
  logic       count_en, set_en, clr_sec;
  logic       sec_wrap, min_wrap, hour_wrap;

  // Wraps to 00 at 'last', otherwise a per-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return '0;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // in_d follows in_1hz even under reset, so a high input at release is not a tick.
  always_ff @(posedge clk_100mhz)
    in_d <= in_1hz;

  assign tick      = in_1hz & ~in_d;
  assign sec_wrap  = (sec_q  == 8'h59);
  assign min_wrap  = (min_q  == 8'h59);
  assign hour_wrap = (hour_q == 8'h23);

  always_ff @(posedge clk_100mhz) begin
    if (rst_100mhz)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: if (set_mode)  state_nxt = SET;
      SET: if (!set_mode) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // set_mode takes priority over a coincident tick, including on the SET entry edge.
  always_comb begin
    count_en = (state == RUN) && !set_mode && tick;
    set_en   = (state == SET);
    clr_sec  = set_mode;
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_100mhz) begin
      sec_q      <= '0;
      min_q      <= INIT_MIN;
      hour_q     <= INIT_HOUR;
      tick_sec   <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
    end else begin
      tick_sec   <= count_en;
      hour_pulse <= count_en && sec_wrap && min_wrap;
      day_pulse  <= count_en && sec_wrap && min_wrap && hour_wrap;

      if (clr_sec)
        sec_q <= '0;
      else if (count_en)
        sec_q <= bcd_inc(sec_q, 8'h59);

      if ((set_en && inc_min) || (count_en && sec_wrap))
        min_q <= bcd_inc(min_q, 8'h59);

      if ((set_en && inc_hour) || (count_en && sec_wrap && min_wrap))
        hour_q <= bcd_inc(hour_q, 8'h23);
    end
  end

  assign sec_bcd = sec_q;
  assign min_bcd = min_q;

`ifdef CLOCK_12H_EN
  logic [4:0] hour_bin;
  logic [4:0] hour_12;

  always_comb begin
    hour_bin = 5'(hour_q[7:4]) * 5'd10 + {1'b0, hour_q[3:0]};
    if (hour_bin == 5'd0)
      hour_12 = 5'd12;
    else if (hour_bin > 5'd12)
      hour_12 = hour_bin - 5'd12;
    else
      hour_12 = hour_bin;
    hour_bcd = (hour_12 >= 5'd10) ? {4'd1, 4'(hour_12 - 5'd10)} : {4'd0, hour_12[3:0]};
    pm       = (hour_bin >= 5'd12);
  end
`else
  assign hour_bcd = hour_q;
  assign pm       = 1'b0;
`endif

endmodule
